// File: rtl/uart_rx_flowctl.sv
// uart_rx_flowctl: UART receiver (8N1, LSB first) feeding a show-ahead FIFO, with registered active-low RTS.
// Optional: define UART_RX_PARITY_EN for 8E1 framing and a sticky parity_err output.
module uart_rx_flowctl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_MARGIN   = 4
) (
  input  logic                        sysclk,
  input  logic                        sysreset_n,
  input  logic                        rxd,
  output logic                        rts_n,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    RTS_THRESH = CW'(FIFO_DEPTH - RTS_MARGIN);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;

  logic             sync1_q, sync2_q, rx_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_evt, frame_set, byte_ok;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rts_n_q, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic             full, empty, pop, wr_en;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_set, parity_err_q, parity_err_d;
  assign byte_ok = ~par_bad_q;
`else
  assign byte_ok = 1'b1;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push_evt  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Re-check the line half a bit in so short glitches are rejected.
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d      = '0;
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = ST_PARITY;
`else
          if (idx_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d  = '0;
          par_bad_d  = (^shreg_q) ^ rx_s;
          parity_set = par_bad_d;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            push_evt = byte_ok;
            state_d  = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bit_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    pop      = !empty && rd_ready;
    // A push into a full FIFO still lands if a pop frees the slot this cycle.
    wr_en    = push_evt && (!full || pop);
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    frame_err_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_d   = (push_evt && full && !pop) ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rts_n_q     <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rts_n_q     <= (count_q >= RTS_THRESH);
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_ptr_q] <= shreg_q;
  end

  assign rd_valid   = !empty;
  assign rd_data    = empty ? 8'h00 : mem[rd_ptr_q];
  assign fifo_count = count_q;
  assign rts_n      = rts_n_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
